// File: rtl/lzd_normalizer.sv
// Sequential normaliser: shifts an accepted operand left one bit per clock until
// its MSB is set, then holds the mantissa and leading-zero count for the consumer.
module lzd_normalizer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [CNT_W-1:0] out_lz,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  // An accept can only occur in IDLE or DONE, so it overrides the per-state update.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    unique case (state_q)
      SHIFT: begin
        if (sr_q[WIDTH-1]) begin
          state_d = DONE;
        end else begin
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      if (in_data == '0) begin
        sr_d    = '0;
        cnt_d   = CNT_W'(WIDTH);
        zero_d  = 1'b1;
        state_d = DONE;
      end else begin
        sr_d    = in_data;
        cnt_d   = '0;
        zero_d  = 1'b0;
        state_d = SHIFT;
      end
    end
  end

  // In DONE the block is ready exactly when the current result drains.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign out_mant = sr_q;
  assign out_lz   = cnt_q;
  assign out_zero = zero_q;

endmodule

// File: tb/tb_lzd_normalizer.sv
// Directed and randomised checks of lzd_normalizer against a scoreboard of
// expected mantissa, count, zero flag and accept-to-valid latency.
module tb_lzd_normalizer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mant;
  logic [3:0] out_lz;
  logic       out_zero;

  typedef struct {
    logic [7:0] mant;
    logic [3:0] lz;
    logic       zero;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;

  lzd_normalizer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_lz    (out_lz),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_lz(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) return 4'(7 - i);
    end
    return 4'd8;
  endfunction

  function automatic logic [7:0] ref_mant(input logic [7:0] d);
    logic [7:0] m;
    m = d;
    if (m == 8'h00) return 8'h00;
    while (!m[7]) m = m << 1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one operand, pushes its expected result and completes the accept edge.
  task automatic applyStimulus(input logic [7:0] d);
    exp_t e;
    e.lz   = ref_lz(d);
    e.mant = ref_mant(d);
    e.zero = (d == 8'h00);
    e.lat  = e.zero ? 0 : int'(e.lz) + 1;
    sb_q.push_back(e);
    in_data  = d;
    in_valid = 1'b1;
    #1;
    check("in_ready_at_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic checkOutput(input int lat);
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    last_exp = e;
    check("out_valid", out_valid, 1);
    check("out_mant", out_mant, e.mant);
    check("out_lz", out_lz, e.lz);
    check("out_zero", out_zero, e.zero);
    check("latency", lat, e.lat);
    check("msb_vs_zero", out_mant[7], !e.zero);
  endtask

  task automatic waitResult();
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput(lat);
  endtask

  // Holds the result for a number of stall cycles, then drains it.
  task automatic consume(input int stall);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_mant", out_mant, last_exp.mant);
      check("stall_lz", out_lz, last_exp.lz);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drained_valid", out_valid, 0);
  endtask

  initial begin
    int         idle_valid;
    logic [7:0] d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_mant", out_mant, 0);
    check("rst_out_lz", out_lz, 0);
    check("rst_out_zero", out_zero, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    applyStimulus(8'h80); waitResult(); consume(0);
    applyStimulus(8'h01); waitResult(); consume(1);
    applyStimulus(8'h2C); waitResult(); consume(0);
    applyStimulus(8'h00); waitResult(); consume(2);

    // Backpressure then a back-to-back accept on the draining edge.
    applyStimulus(8'h13);
    waitResult();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_mant", out_mant, last_exp.mant);
      check("bp_lz", out_lz, last_exp.lz);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    applyStimulus(8'h40);
    out_ready = 1'b0;
    waitResult();
    consume(0);

    // Reset in the middle of a shift sequence discards the operand.
    applyStimulus(8'h01);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_mant", out_mant, 0);
    check("midrst_lz", out_lz, 0);
    check("midrst_zero", out_zero, 0);
    sb_q.delete();
    #6;
    rst_n = 1'b1;
    idle_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) idle_valid++;
    end
    check("no_stale_result", idle_valid, 0);
    check("post_rst_in_ready", in_ready, 1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) d = 8'h00;
      else d = 8'($urandom_range(1, 255));
      applyStimulus(d);
      waitResult();
      consume(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
